// File: rtl/add_arbiter.sv
// Round-robin arbiter that shares one 32-bit carry-lookahead adder among NREQ requesters.
// 64-bit adds take two adder passes (low half, then high half with the low carry).
module add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ-1:0]   req_wide_i,
    input  logic [NREQ-1:0]   req_cin_i,
    input  logic [NREQ*64-1:0] req_a_i,
    input  logic [NREQ*64-1:0] req_b_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [IDW-1:0]    resp_id_o,
    output logic [63:0]       resp_sum_o,
    output logic              resp_carry_o,
    output logic              resp_wide_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [63:0]     a_q, a_d;
    logic [63:0]     b_q, b_d;
    logic            cin_q, cin_d;
    logic            wide_q, wide_d;
    logic [63:0]     sum_q, sum_d;
    logic            c_lo_q, c_lo_d;
    logic            carry_q, carry_d;

    // Arbitration signals
    logic [2*NREQ-1:0] dbl_valid;
    logic [NREQ-1:0]   rot_valid;
    logic [IDW-1:0]    rot_off;
    logic [IDW:0]      grant_sum;
    logic [IDW:0]      ptr_inc;
    logic [IDW-1:0]    grant_idx;
    logic              any_valid;
    logic              grant_fire;
    logic [63:0]       sel_a;
    logic [63:0]       sel_b;
    logic              sel_cin;
    logic              sel_wide;

    // Adder signals
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic [31:0] cla_g;
    logic [31:0] cla_p;
    logic [31:0] cla_c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic [3:0]  blk_g;
    logic [3:0]  blk_p;
    logic        blk_c;

    // Rotate the valid vector so the search always starts at bit 0, then map back.
    always_comb begin
        dbl_valid = {req_valid_i, req_valid_i} >> ptr_q;
        rot_valid = dbl_valid[NREQ-1:0];
        rot_off   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                rot_off = IDW'(k);
            end
        end
        any_valid = |req_valid_i;
        grant_sum = {1'b0, ptr_q} + {1'b0, rot_off};
        if (grant_sum >= (IDW+1)'(NREQ)) begin
            grant_sum = grant_sum - (IDW+1)'(NREQ);
        end
        grant_idx = grant_sum[IDW-1:0];
        ptr_inc   = {1'b0, grant_idx} + 1'b1;
        if (ptr_inc == (IDW+1)'(NREQ)) begin
            ptr_inc = '0;
        end
        grant_fire = (state_q == StIdle) && !rst_i && any_valid;
        req_ready_o = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_cin     = 1'b0;
        sel_wide    = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (grant_idx == IDW'(k)) begin
                req_ready_o[k] = grant_fire;
                sel_a          = req_a_i[k*64 +: 64];
                sel_b          = req_b_i[k*64 +: 64];
                sel_cin        = req_cin_i[k];
                sel_wide       = req_wide_i[k];
            end
        end
    end

    always_comb begin
        add_a   = a_q[31:0];
        add_b   = b_q[31:0];
        add_cin = cin_q;
        if (state_q == StHi) begin
            add_a   = a_q[63:32];
            add_b   = b_q[63:32];
            add_cin = c_lo_q;
        end
    end

    // Two-level carry lookahead: 4-bit blocks, block carries from group generate/propagate.
    always_comb begin
        cla_g = add_a & add_b;
        cla_p = add_a ^ add_b;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        cla_c = '0;
        blk_g = '0;
        blk_p = '0;
        blk_c = 1'b0;
        for (int j = 0; j < 8; j++) begin
            blk_g    = cla_g[4*j +: 4];
            blk_p    = cla_p[4*j +: 4];
            grp_g[j] = blk_g[3] | (blk_p[3] & blk_g[2]) | (blk_p[3] & blk_p[2] & blk_g[1])
                     | (blk_p[3] & blk_p[2] & blk_p[1] & blk_g[0]);
            grp_p[j] = &blk_p;
        end
        grp_c[0] = add_cin;
        for (int j = 0; j < 8; j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
        for (int j = 0; j < 8; j++) begin
            blk_g = cla_g[4*j +: 4];
            blk_p = cla_p[4*j +: 4];
            blk_c = grp_c[j];
            cla_c[4*j]   = blk_c;
            cla_c[4*j+1] = blk_g[0] | (blk_p[0] & blk_c);
            cla_c[4*j+2] = blk_g[1] | (blk_p[1] & blk_g[0]) | (blk_p[1] & blk_p[0] & blk_c);
            cla_c[4*j+3] = blk_g[2] | (blk_p[2] & blk_g[1]) | (blk_p[2] & blk_p[1] & blk_g[0])
                         | (blk_p[2] & blk_p[1] & blk_p[0] & blk_c);
        end
        add_sum  = cla_p ^ cla_c;
        add_cout = grp_c[8];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        wide_d  = wide_q;
        sum_d   = sum_q;
        c_lo_d  = c_lo_q;
        carry_d = carry_q;
        unique case (state_q)
            StIdle: begin
                if (grant_fire) begin
                    id_d    = grant_idx;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    cin_d   = sel_cin;
                    wide_d  = sel_wide;
                    ptr_d   = ptr_inc[IDW-1:0];
                    state_d = StLo;
                end
            end
            StLo: begin
                sum_d[31:0] = add_sum;
                c_lo_d      = add_cout;
                if (wide_q) begin
                    state_d = StHi;
                end else begin
                    sum_d[63:32] = '0;
                    carry_d      = add_cout;
                    state_d      = StResp;
                end
            end
            StHi: begin
                sum_d[63:32] = add_sum;
                carry_d      = add_cout;
                state_d      = StResp;
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            wide_q  <= 1'b0;
            sum_q   <= '0;
            c_lo_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            wide_q  <= wide_d;
            sum_q   <= sum_d;
            c_lo_q  <= c_lo_d;
            carry_q <= carry_d;
        end
    end

    assign resp_valid_o = (state_q == StResp);
    assign resp_id_o    = id_q;
    assign resp_sum_o   = sum_q;
    assign resp_carry_o = carry_q;
    assign resp_wide_o  = wide_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: directed scenarios plus a randomized run against a transaction-level
// model (wide arithmetic, first-valid-from-pointer arbitration, fixed latencies).
module tb_add_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, req_wide, req_cin;
    logic [N*64-1:0] req_a, req_b;
    logic           resp_valid, resp_ready;
    logic [IW-1:0]  resp_id;
    logic [63:0]    resp_sum;
    logic           resp_carry, resp_wide, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [63:0]   sum;
        logic          carry;
        logic          wide;
    } exp_t;

    always #5 clk = ~clk;

    add_arbiter #(.NREQ(N), .IDW(IW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_wide_i  (req_wide),
        .req_cin_i   (req_cin),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_id_o   (resp_id),
        .resp_sum_o  (resp_sum),
        .resp_carry_o(resp_carry),
        .resp_wide_o (resp_wide),
        .busy_o      (busy)
    );

    // {carry, sum} of the full-precision add
    function automatic logic [64:0] ref_add(input logic wide, input logic cin,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [32:0] s;
        if (wide) return {1'b0, a} + {1'b0, b} + {64'd0, cin};
        s = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, cin};
        return {s[32], 32'd0, s[31:0]};
    endfunction

    function automatic exp_t model(input int id);
        exp_t e;
        logic [64:0] r;
        r = ref_add(req_wide[id], req_cin[id], req_a[id*64 +: 64], req_b[id*64 +: 64]);
        e.id    = IW'(id);
        e.sum   = r[63:0];
        e.carry = r[64];
        e.wide  = req_wide[id];
        return e;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_req(input int id, input logic wide, input logic cin,
                           input logic [63:0] a, input logic [63:0] b);
        req_wide[id]        = wide;
        req_cin[id]         = cin;
        req_a[id*64 +: 64]  = a;
        req_b[id*64 +: 64]  = b;
    endtask

    // Drives one request and waits for its response; obs = {id, sum, carry, wide}.
    task automatic do_txn(input int id, input logic wide, input logic cin,
                          input logic [63:0] a, input logic [63:0] b,
                          output bit ok, output int lat, output logic [67:0] obs);
        ok  = 0;
        lat = 0;
        obs = '0;
        @(posedge clk); #1;
        set_req(id, wide, cin, a, b);
        req_valid[id] = 1'b1;
        resp_ready    = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = (req_ready[id] === 1'b1);
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (!ok) return;
        ok = 0;
        for (int i = 1; i <= 10 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                ok  = 1;
                lat = i;
                obs = {resp_id, resp_sum, resp_carry, resp_wide};
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        req_valid  = '1;
        req_wide   = '0;
        req_cin    = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== '0) begin
                n_fail++;
                $display("FAIL reset_ready: got %b want 0000", req_ready);
            end
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b busy=%b want 0 0", resp_valid, busy);
        end
        n_cmp++;
        if ({resp_id, resp_sum, resp_carry, resp_wide} !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: id=%0d sum=%h c=%b w=%b want all 0",
                     resp_id, resp_sum, resp_carry, resp_wide);
        end
    endtask

    task automatic test_round_robin;
        exp_t q[$];
        exp_t e;
        int n_gnt = 0;
        int n_rsp = 0;
        int g;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom});
        end
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int cyc = 0; cyc < 80 && n_rsp < 6; cyc++) begin
            @(negedge clk);
            g = -1;
            if (req_ready !== '0) begin
                g = idx_of(req_ready);
                n_cmp++;
                if (g != n_gnt % N || $countones(req_ready) != 1) begin
                    n_fail++;
                    $display("FAIL rr_grant: got ready=%b want grant %0d", req_ready, n_gnt % N);
                end
                q.push_back(model(g));
                n_gnt++;
            end
            if (resp_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_spurious: response id=%0d with none pending", resp_id);
                end else begin
                    e = q.pop_front();
                    if (resp_id !== e.id || resp_sum !== e.sum || resp_carry !== e.carry
                        || resp_wide !== e.wide) begin
                        n_fail++;
                        $display("FAIL rr_resp: got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                                 resp_id, resp_sum, resp_carry, e.id, e.sum, e.carry);
                    end
                end
                n_rsp++;
            end
            @(posedge clk); #1;
            if (g >= 0) begin
                set_req(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        {$urandom, $urandom}, {$urandom, $urandom});
            end
            if (n_gnt >= 6) req_valid = '0;
        end
        req_valid = '0;
        n_cmp++;
        if (n_rsp != 6) begin
            n_fail++;
            $display("FAIL rr_count: got %0d responses want 6", n_rsp);
        end
    endtask

    task automatic test_directed;
        int           t_id[4]    = '{0, 2, 3, 1};
        logic         t_wide[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic         t_cin[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0]  t_a[4]     = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                                     64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_8000_0000};
        logic [63:0]  t_b[4]     = '{64'h1, 64'h1, 64'h0, 64'hFFFF_0000_8000_0001};
        logic [63:0]  t_sum[4]   = '{64'h0, 64'h0000_0001_0000_0000, 64'h0, 64'h2};
        logic         t_carry[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit           ok;
        int           lat;
        logic [67:0]  obs;
        for (int i = 0; i < 4; i++) begin
            do_txn(t_id[i], t_wide[i], t_cin[i], t_a[i], t_b[i], ok, lat, obs);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL dir%0d_timeout: got no grant/response want one", i);
                continue;
            end
            n_cmp++;
            if (lat != (t_wide[i] ? 3 : 2)) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, t_wide[i] ? 3 : 2);
            end
            n_cmp++;
            if (obs[65:2] !== t_sum[i] || obs[1] !== t_carry[i]) begin
                n_fail++;
                $display("FAIL dir%0d_sum: got %h c=%b want %h c=%b",
                         i, obs[65:2], obs[1], t_sum[i], t_carry[i]);
            end
            n_cmp++;
            if (obs[67:66] !== IW'(t_id[i]) || obs[0] !== t_wide[i]) begin
                n_fail++;
                $display("FAIL dir%0d_tag: got id=%0d w=%b want id=%0d w=%b",
                         i, obs[67:66], obs[0], t_id[i], t_wide[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        exp_t        e0, e1;
        logic [67:0] snap;
        bit          ok = 0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        req_valid  = 4'b0001;
        resp_ready = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[0] === 1'b1) begin
                ok = 1;
                e0 = model(0);
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_grant0: got no grant want grant of requester 0");
            req_valid = '0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 4'b0010;
        set_req(1, 1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = (resp_valid === 1'b1);
        end
        snap = {resp_id, resp_sum, resp_carry, resp_wide};
        n_cmp++;
        if (!ok || snap !== {e0.id, e0.sum, e0.carry, e0.wide}) begin
            n_fail++;
            $display("FAIL bp_resp0: got valid=%b obs=%h want valid=1 obs=%h",
                     resp_valid, snap, {e0.id, e0.sum, e0.carry, e0.wide});
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++;
            if (resp_valid !== 1'b1 || {resp_id, resp_sum, resp_carry, resp_wide} !== snap
                || req_ready !== '0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stable%0d: got v=%b obs=%h rdy=%b busy=%b want v=1 obs=%h",
                         k, resp_valid, {resp_id, resp_sum, resp_carry, resp_wide},
                         req_ready, busy, snap);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        e1 = model(1);
        n_cmp++;
        if (resp_valid !== 1'b1 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL bp_handshake: got v=%b rdy=%b want v=1 rdy=0000", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_grant1: got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = (resp_valid === 1'b1);
        end
        n_cmp++;
        if (!ok || {resp_id, resp_sum, resp_carry, resp_wide} !== {e1.id, e1.sum, e1.carry, e1.wide})
        begin
            n_fail++;
            $display("FAIL bp_resp1: got v=%b sum=%h want v=1 sum=%h", resp_valid, resp_sum, e1.sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        bit ok = 0;
        int lat = 0;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        set_req(2, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_FFFF_FFFF);
        req_valid = 4'b0100;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = (req_ready[2] === 1'b1);
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_grant: got no grant want grant of requester 2");
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hi_state: got busy=%b v=%b want busy=1 v=0", busy, resp_valid);
        end
        rst       = 1'b1;
        req_valid = '1;
        set_req(0, 1'b0, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'h1);
        #1;
        n_cmp++;
        if (req_ready !== '0) begin
            n_fail++;
            $display("FAIL rst_ready: got %b want 0000", req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_sum !== '0 || resp_id !== '0) begin
            n_fail++;
            $display("FAIL rst_clear: got v=%b busy=%b sum=%h id=%0d want 0 0 0 0",
                     resp_valid, busy, resp_sum, resp_id);
        end
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_ptr: got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        ok = 0;
        for (int i = 1; i <= 10 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                ok  = 1;
                lat = i;
            end
        end
        n_cmp++;
        if (!ok || lat != 2 || resp_id !== 2'd0 || resp_sum !== 64'h8000_0000
            || resp_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: got v=%b lat=%0d id=%0d sum=%h want 1 2 0 80000000",
                     resp_valid, lat, resp_id, resp_sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        bit   inflight = 0;
        int   ptr      = 0;
        int   rise     = 0;
        int   n_done   = 0;
        int   g;
        bit   hs;
        bit   exp_vld;
        logic [N-1:0] exp_rdy;
        exp_t cur;
        @(posedge clk); #1;
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== inflight) begin
                n_fail++;
                $display("FAIL rnd_busy: cycle %0d got %b want %b", cyc, busy, inflight);
            end
            exp_vld = inflight && (cyc >= rise);
            n_cmp++;
            if (resp_valid !== exp_vld) begin
                n_fail++;
                $display("FAIL rnd_valid: cycle %0d got %b want %b", cyc, resp_valid, exp_vld);
            end
            hs = 0;
            if (exp_vld && resp_valid === 1'b1) begin
                n_cmp++;
                if (resp_id !== cur.id || resp_sum !== cur.sum || resp_carry !== cur.carry
                    || resp_wide !== cur.wide) begin
                    n_fail++;
                    $display("FAIL rnd_resp: cycle %0d got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                             cyc, resp_id, resp_sum, resp_carry, cur.id, cur.sum, cur.carry);
                end
                hs = resp_ready;
            end
            g       = inflight ? -1 : rr_pick(ptr, req_valid);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rnd_ready: cycle %0d got %b want %b", cyc, req_ready, exp_rdy);
            end
            if (g >= 0) begin
                cur      = model(g);
                inflight = 1;
                rise     = cyc + (req_wide[g] ? 3 : 2);
                ptr      = (g + 1) % N;
            end
            if (hs) begin
                inflight = 0;
                n_done++;
            end
            @(posedge clk); #1;
            if (g >= 0) req_valid[g] = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
                    set_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            {$urandom, $urandom}, {$urandom, $urandom});
                    req_valid[k] = 1'b1;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        n_cmp++;
        if (n_done < 30) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d completions want at least 30", n_done);
        end
        repeat (5) @(posedge clk);
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_directed;
        test_backpressure;
        test_reset_mid_op;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shared-adder arbiter and sequencer: accepts add requests from NREQ independent requesters, grants the single 32-bit carry-lookahead adder datapath round-robin, and returns one registered, tagged result per request. Supports 32-bit adds and 64-bit adds; a 64-bit add is sequenced as two passes through the same adder, with the low-half carry fed into the high half. Sits between the ALU front-end requesters and the adder instance, so the ALU needs only one adder.

## Interface
- NREQ, 4, number of requesters; 2..8
- IDW, $clog2(NREQ), width of the requester ID tag
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_wide  in  NREQ  1 = 64-bit add, 0 = 32-bit add
- req_cin  in  NREQ  carry-in of bit 0
- req_a  in  NREQ*64  operand A; requester i at [64i+63:64i]; narrow ops use the low 32 bits
- req_b  in  NREQ*64  operand B; same packing as req_a
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts the result
- resp_id  out  IDW  index of the requester that owns the result
- resp_sum  out  64  sum; bits [63:32] are 0 for narrow ops
- resp_carry  out  1  carry-out of bit 31 (narrow) or bit 63 (wide)
- resp_wide  out  1  copy of the request's wide flag
- busy  out  1  high in every state except IDLE

## Operation
- One transaction in flight; no overlap.
- States: IDLE, LO, HI, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from ptr, with wrap-around.
  - Assert req_ready[g] combinationally in the same cycle.
  - Capture a, b, cin, wide and g into internal registers.
  - Set ptr to (g+1) mod NREQ.
  - Go to LO.
  - No valid: stay in IDLE; ptr is unchanged.
- LO:
  - Drive the adder with a[31:0], b[31:0], cin.
  - Register the 32-bit sum into sum[31:0] and the carry-out into c_lo.
  - Wide op: go to HI. Narrow op: set sum[63:32]=0, resp_carry=c_lo, and go to RESP.
- HI:
  - Drive the adder with a[63:32], b[63:32], c_lo.
  - Register the result into sum[63:32] and the carry-out into resp_carry.
  - Go to RESP.
- RESP:
  - resp_valid=1; all resp_* outputs stay stable.
  - When resp_ready=1, go to IDLE.
  - No new grant is issued in the cycle resp_ready is taken; the next grant is possible one cycle later.
- Arithmetic is modulo 2^32 for narrow ops and 2^64 for wide ops. resp_carry is the true carry-out.
- req_ready depends on req_valid. A requester must not make req_valid depend on req_ready.
- A requester may hold req_valid high across cycles. Its operands are sampled only in its grant cycle.
- Reset:
  - state=IDLE, ptr=0, resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0, resp_wide=0, busy=0, req_ready=0.
  - An asserted rst overrides every state. A transaction in flight is dropped and produces no response.
  - While rst=1, req_ready=0 even if req_valid is set.

## Timing
- Accept at cycle T (req_valid[g] & req_ready[g]).
  - Narrow op: resp_valid rises at T+2.
  - Wide op: resp_valid rises at T+3.
- With resp_ready held at 1, steady-state throughput is:
  - one narrow op per 3 cycles;
  - one wide op per 4 cycles.
- The adder is purely combinational; one adder pass per cycle. No combinational path from req_* to resp_*.
- busy is high from T+1 through the cycle resp_ready is taken.
- Fairness: with all NREQ requesters continuously valid, grants cycle 0,1,2,…,NREQ-1,0. Worst-case wait is NREQ-1 transactions.

## Test plan
- Narrow add, requester 0:
  - Stimulus: a=0xFFFF_FFFF, b=0x1, cin=0, resp_ready=1.
  - Required: resp_sum=0x0000_0000_0000_0000, resp_carry=1, resp_id=0, resp_valid exactly at T+2.
- Wide add, requester 2:
  - Stimulus: a=0x0000_0000_FFFF_FFFF, b=0x1, cin=0.
  - Required: resp_sum=0x0000_0001_0000_0000, resp_carry=0, resp_wide=1, resp_valid at T+3.
- Wide overflow with carry-in:
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1.
  - Required: resp_sum=0, resp_carry=1.
- Round-robin:
  - Stimulus: all 4 req_valid held high, resp_ready=1, distinct operands per requester.
  - Required: grant order is 0,1,2,3,0,1; each resp_id matches its operands; no requester starved.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after resp_valid rises; requester 1 held valid.
  - Required: resp_* stable throughout; req_ready stays 0; requester 1 is granted only after the resp_ready handshake plus one cycle.
- Reset mid-operation:
  - Stimulus: assert rst during the HI state of a wide op.
  - Required: next cycle state=IDLE, resp_valid=0, busy=0, ptr=0; no response for the dropped op; a new request after reset completes normally.
